// File: rtl/tipi_nib_host.sv
// tipi_nib_host: host-side master for the TIPI nibble bus. One byte-level
// register request at a time is framed as reset slot, command nibble and two
// data nibbles (high first); reads return the byte on a one-cycle response.
module tipi_nib_host #(
  parameter int HALF_PERIOD = 4,
  parameter int TURN        = 2
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_reg,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       r_clk,
  output logic       r_nibrst,
  output logic [3:0] r_nib_out,
  output logic       r_nib_oe,
  input  logic [3:0] r_nib_in
);

  // 2*255-1 fits in 9 bits; TURN-1 (max 14) shares the same counter.
  localparam int                CW        = 9;
  localparam logic [CW-1:0]     SLOT_LAST = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0]     HALF      = CW'(HALF_PERIOD);
  localparam logic [CW-1:0]     TURN_LAST = CW'(TURN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_CMD,
    S_TURN,
    S_DATA_HI,
    S_DATA_LO,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          write_q;
  logic [1:0]    reg_q;
  logic [7:0]    data_q;
  logic [3:0]    hi_q;
  logic [7:0]    rsp_data_q;

  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          r_clk_q, r_clk_d;
  logic          nibrst_q, nibrst_d;
  logic [3:0]    nib_out_q, nib_out_d;
  logic          nib_oe_q, nib_oe_d;

  logic          accept;
  logic          slot_end;

  assign accept   = (state_q == S_IDLE) && ready_q && req_valid;
  assign slot_end = (cnt_q == SLOT_LAST);

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign r_clk     = r_clk_q;
  assign r_nibrst  = nibrst_q;
  assign r_nib_out = nib_out_q;
  assign r_nib_oe  = nib_oe_q;

  // State and slot counter registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!r_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus next pad values; pads are decoded from the next state so
  // that their registered copies line up exactly with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    r_clk_d     = 1'b0;
    nibrst_d    = 1'b0;
    nib_out_d   = 4'h0;
    nib_oe_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_RST;
      end
      S_RST, S_CMD, S_DATA_HI, S_DATA_LO: begin
        if (slot_end) begin
          cnt_d = '0;
          case (state_q)
            S_RST:     state_d = S_CMD;
            S_CMD:     state_d = write_q ? S_DATA_HI : S_TURN;
            S_DATA_HI: state_d = S_DATA_LO;
            default:   state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    nibrst_d    = (state_d == S_RST);
    r_clk_d     = ((state_d == S_CMD) || (state_d == S_DATA_HI) || (state_d == S_DATA_LO))
                  && (cnt_d >= HALF);

    case (state_d)
      S_CMD: begin
        nib_oe_d  = 1'b1;
        nib_out_d = {1'b1, write_q, reg_q};
      end
      S_DATA_HI: begin
        nib_oe_d  = write_q;
        nib_out_d = write_q ? data_q[7:4] : 4'h0;
      end
      S_DATA_LO: begin
        nib_oe_d  = write_q;
        nib_out_d = write_q ? data_q[3:0] : 4'h0;
      end
      default: begin
        nib_oe_d  = 1'b0;
        nib_out_d = 4'h0;
      end
    endcase
  end

  // Registered pad and handshake outputs, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!r_reset) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      r_clk_q     <= 1'b0;
      nibrst_q    <= 1'b0;
      nib_out_q   <= 4'h0;
      nib_oe_q    <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      r_clk_q     <= r_clk_d;
      nibrst_q    <= nibrst_d;
      nib_out_q   <= nib_out_d;
      nib_oe_q    <= nib_oe_d;
    end
  end

  // Request capture and read-nibble sampling on the last cycle of each data slot.
  always_ff @(posedge clk) begin
    if (!r_reset) begin
      write_q    <= 1'b0;
      reg_q      <= 2'd0;
      data_q     <= 8'h00;
      hi_q       <= 4'h0;
      rsp_data_q <= 8'h00;
    end else begin
      if (accept) begin
        write_q <= req_write;
        reg_q   <= req_reg;
        data_q  <= req_data;
      end
      if ((state_q == S_DATA_HI) && slot_end && !write_q) begin
        hi_q <= r_nib_in;
      end
      if ((state_q == S_DATA_LO) && slot_end) begin
        rsp_data_q <= write_q ? 8'h00 : {hi_q, r_nib_in};
      end
    end
  end

endmodule

// File: tb/tb_tipi_nib_host.sv
// tb_tipi_nib_host: directed bench for tipi_nib_host. Instance 0 uses the
// default timing, instance 1 uses HALF_PERIOD=1/TURN=1. A small CPLD model per
// instance holds four byte registers written and read over the nibble bus.
module tb_tipi_nib_host;

  logic       clk = 1'b0;
  logic       r_reset = 1'b0;

  logic [1:0] valid_w = 2'b00;
  logic [1:0] write_w = 2'b00;
  logic [1:0] reg_w  [2];
  logic [7:0] data_w [2];
  logic [1:0] ready_w;
  logic [1:0] rsp_w;
  logic [7:0] rdata_w [2];
  logic [1:0] rclk_w;
  logic [1:0] nibrst_w;
  logic [3:0] nout_w [2];
  logic [1:0] oe_w;
  logic [3:0] nin_w  [2];

  int checks = 0;
  int errors = 0;

  // Per-cycle trace of the transfer in progress, index = cycle after handshake.
  logic       tr_clk    [0:71];
  logic       tr_nibrst [0:71];
  logic [3:0] tr_nout   [0:71];
  logic       tr_oe     [0:71];
  logic       tr_ready  [0:71];
  logic       tr_rsp    [0:71];

  // CPLD model state.
  int         rises [2];
  logic       prev  [2];
  logic       mwr   [2];
  logic [1:0] mreg  [2];
  logic [3:0] mhi   [2];
  logic [7:0] regs  [2][4];

  always #5 clk = ~clk;

  tipi_nib_host dut0 (
    .clk(clk), .r_reset(r_reset),
    .req_valid(valid_w[0]), .req_ready(ready_w[0]), .req_write(write_w[0]),
    .req_reg(reg_w[0]), .req_data(data_w[0]),
    .rsp_valid(rsp_w[0]), .rsp_data(rdata_w[0]),
    .r_clk(rclk_w[0]), .r_nibrst(nibrst_w[0]), .r_nib_out(nout_w[0]),
    .r_nib_oe(oe_w[0]), .r_nib_in(nin_w[0])
  );

  tipi_nib_host #(.HALF_PERIOD(1), .TURN(1)) dut1 (
    .clk(clk), .r_reset(r_reset),
    .req_valid(valid_w[1]), .req_ready(ready_w[1]), .req_write(write_w[1]),
    .req_reg(reg_w[1]), .req_data(data_w[1]),
    .rsp_valid(rsp_w[1]), .rsp_data(rdata_w[1]),
    .r_clk(rclk_w[1]), .r_nibrst(nibrst_w[1]), .r_nib_out(nout_w[1]),
    .r_nib_oe(oe_w[1]), .r_nib_in(nin_w[1])
  );

  // CPLD model: sequencer restarts on r_nibrst; acts on r_clk edges seen mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!r_reset || nibrst_w[k]) begin
        rises[k] <= 0;
      end else if (rclk_w[k] && !prev[k]) begin
        rises[k] <= rises[k] + 1;
        if (rises[k] == 0) begin
          mwr[k]  <= nout_w[k][2];
          mreg[k] <= nout_w[k][1:0];
          if (!nout_w[k][2]) nin_w[k] <= regs[k][nout_w[k][1:0]][7:4];
        end else if (rises[k] == 1 && mwr[k]) begin
          mhi[k] <= nout_w[k];
        end else if (rises[k] == 2 && mwr[k]) begin
          regs[k][mreg[k]] <= {mhi[k], nout_w[k]};
        end
      end else if (!rclk_w[k] && prev[k] && rises[k] == 2 && !mwr[k]) begin
        nin_w[k] <= regs[k][mreg[k]][3:0];
      end
      prev[k] <= rclk_w[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One request on instance i; optional reset pulse at cycle abort_at.
  task automatic xfer(input int i, input bit wr, input logic [1:0] rg, input logic [7:0] d,
                      input int abort_at, output int waited, output int rsp_cyc,
                      output logic [7:0] rsp_d);
    waited  = 0;
    rsp_cyc = -1;
    rsp_d   = 8'h00;
    @(negedge clk);
    while (!ready_w[i] && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!ready_w[i]) check("ready_timeout", {31'd0, ready_w[i]}, 32'd1);
    valid_w[i] = 1'b1;
    write_w[i] = wr;
    reg_w[i]   = rg;
    data_w[i]  = d;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (n == 1) begin
        valid_w[i] = 1'b0;
        data_w[i]  = ~d;
        reg_w[i]   = ~rg;
        write_w[i] = ~wr;
      end
      tr_clk[n]    = rclk_w[i];
      tr_nibrst[n] = nibrst_w[i];
      tr_nout[n]   = nout_w[i];
      tr_oe[n]     = oe_w[i];
      tr_ready[n]  = ready_w[i];
      tr_rsp[n]    = rsp_w[i];
      if (abort_at != 0 && n == abort_at) r_reset = 1'b0;
      if (abort_at != 0 && n == abort_at + 1) r_reset = 1'b1;
      if (rsp_w[i]) begin
        rsp_cyc = n;
        rsp_d   = rdata_w[i];
        break;
      end
    end
    $display("xfer dut%0d %s reg=%0d data=%02h -> rsp cycle %0d data %02h",
             i, wr ? "WR" : "RD", rg, d, rsp_cyc, rsp_d);
  endtask

  initial begin
    int         w, rc, cnt, unstable, rise_cnt, hi_cnt, oe_cnt;
    logic [7:0] rd;
    logic [3:0] slot_exp [3];
    logic [6:0] clk_pat;

    reg_w[0] = 2'd0; reg_w[1] = 2'd0;
    data_w[0] = 8'h00; data_w[1] = 8'h00;

    // Reset held with a request pending: everything quiet.
    valid_w = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_outputs",
            {14'd0, ready_w, rsp_w, rclk_w, nibrst_w, oe_w, nout_w[0], nout_w[1]}, 32'd0);
    end
    r_reset = 1'b1;
    valid_w = 2'b00;
    @(negedge clk);
    check("ready_after_release", {30'd0, ready_w}, 32'h3);

    // Write RD = A5 on the default instance.
    xfer(0, 1'b1, 2'd2, 8'hA5, 0, w, rc, rd);
    check("wr_rsp_cycle", rc, 32'd33);
    check("wr_rsp_data", {24'd0, rd}, 32'h00);
    cnt = 0;
    for (int n = 1; n <= 33; n++) if (tr_nibrst[n]) cnt++;
    check("wr_nibrst_cycles", cnt, 32'd8);
    check("wr_nibrst_first", {31'd0, tr_nibrst[1]}, 32'd1);
    slot_exp[0] = 4'hE; slot_exp[1] = 4'hA; slot_exp[2] = 4'h5;
    unstable = 0; rise_cnt = 0; hi_cnt = 0; oe_cnt = 0;
    for (int n = 9; n <= 32; n++) begin
      if (tr_nout[n] !== slot_exp[(n - 9) / 8]) unstable++;
      if (tr_clk[n] && !tr_clk[n - 1]) rise_cnt++;
      if (tr_clk[n]) hi_cnt++;
      if (tr_oe[n]) oe_cnt++;
    end
    check("wr_nib_cmd", {28'd0, tr_nout[9]}, 32'hE);
    check("wr_nib_hi", {28'd0, tr_nout[17]}, 32'hA);
    check("wr_nib_lo", {28'd0, tr_nout[25]}, 32'h5);
    check("wr_nib_unstable", unstable, 32'd0);
    check("wr_rclk_pulses", rise_cnt, 32'd3);
    check("wr_rclk_high_cycles", hi_cnt, 32'd12);
    check("wr_oe_cycles", oe_cnt, 32'd24);
    @(negedge clk);
    check("wr_post_rsp_valid", {31'd0, rsp_w[0]}, 32'd0);
    check("wr_post_ready", {31'd0, ready_w[0]}, 32'd1);

    // Load TD = 3C into the model, then read it back.
    xfer(0, 1'b1, 2'd0, 8'h3C, 0, w, rc, rd);
    check("td_wr_rsp_cycle", rc, 32'd33);
    xfer(0, 1'b0, 2'd0, 8'h00, 0, w, rc, rd);
    check("rd_nib_cmd", {28'd0, tr_nout[9]}, 32'h8);
    check("rd_oe_cmd", {31'd0, tr_oe[16]}, 32'd1);
    oe_cnt = 0;
    for (int n = 17; n <= 34; n++) if (tr_oe[n]) oe_cnt++;
    check("rd_oe_off_17_34", oe_cnt, 32'd0);
    check("rd_rsp_cycle", rc, 32'd35);
    check("rd_rsp_data", {24'd0, rd}, 32'h3C);

    // Back-to-back: write TC = FF, then read TC in the very next idle cycle.
    xfer(0, 1'b1, 2'd1, 8'hFF, 0, w, rc, rd);
    check("b2b_wr_rsp_cycle", rc, 32'd33);
    xfer(0, 1'b0, 2'd1, 8'h00, 0, w, rc, rd);
    check("b2b_wait", w, 32'd0);
    check("b2b_rst_cycle1", {31'd0, tr_nibrst[1]}, 32'd1);
    check("b2b_rsp_cycle", rc, 32'd35);
    check("b2b_rsp_data", {24'd0, rd}, 32'hFF);

    // Reset in the middle of a read, then a fresh read.
    xfer(0, 1'b0, 2'd1, 8'h00, 20, w, rc, rd);
    check("abort_no_rsp", rc, 32'hFFFF_FFFF);
    check("abort_pads_released",
          {26'd0, tr_clk[21], tr_nibrst[21], tr_oe[21], tr_ready[21], tr_rsp[21], |tr_nout[21]},
          32'd0);
    xfer(0, 1'b0, 2'd1, 8'h00, 0, w, rc, rd);
    check("after_abort_rsp_cycle", rc, 32'd35);
    check("after_abort_rsp_data", {24'd0, rd}, 32'hFF);

    // HALF_PERIOD=1, TURN=1 instance: write RC = 81, read it back.
    xfer(1, 1'b1, 2'd3, 8'h81, 0, w, rc, rd);
    check("h1_wr_rsp_cycle", rc, 32'd9);
    xfer(1, 1'b0, 2'd3, 8'h00, 0, w, rc, rd);
    clk_pat = {tr_clk[3], tr_clk[4], tr_clk[5], tr_clk[6], tr_clk[7], tr_clk[8], tr_clk[9]};
    check("h1_rclk_pattern", {25'd0, clk_pat}, 32'b0100101);
    check("h1_rsp_cycle", rc, 32'd10);
    check("h1_rsp_data", {24'd0, rd}, 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
